// File: rtl/cpu_types_pkg.sv
// Shared CPU types: instruction-cache frame layout, cache FSM states and a
// saturating counter helper.
package cpu_types_pkg;

  localparam int unsigned WORD_W  = 32;
  localparam int unsigned WADDR_W = 30;

  typedef enum logic {
    COMPARE = 1'b0,
    FETCH   = 1'b1
  } icache_state_t;

  // Tag field is sized for the smallest cache; narrower tags are zero-extended.
  typedef struct packed {
    logic               valid;
    logic [WADDR_W-1:0] tag;
    logic [WORD_W-1:0]  data;
  } icache_frame_t;

  function automatic logic [WORD_W-1:0] sat_inc(input logic [WORD_W-1:0] v);
    return (v == '1) ? v : v + WORD_W'(1);
  endfunction

endpackage

// File: rtl/icache_if.sv
// Instruction-cache bus bundle: datapath request side, memory refill side
// and performance counters.
interface icache_if;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        flush;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  modport slave (
    input  imemREN, imemaddr, flush, iwait, iload,
    output ihit, imemload, iREN, iaddr, hit_count, miss_count
  );

  modport master (
    output imemREN, imemaddr, flush, iwait, iload,
    input  ihit, imemload, iREN, iaddr, hit_count, miss_count
  );
endinterface

// File: rtl/icache.sv
// Direct-mapped, one-word-per-frame instruction cache with zero-cycle hits
// and a blocking single-word refill from memory.
module icache
  import cpu_types_pkg::*;
#(
  parameter int unsigned FRAMES = 16
) (
  input logic     CLK,
  input logic     nRST,
  icache_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(FRAMES);
  localparam int unsigned TAG_W = WADDR_W - IDX_W;

  icache_state_t state_q, state_d;
  icache_frame_t frames_q [FRAMES];
  icache_frame_t req_frame;

  logic [31:0] miss_addr_q, miss_addr_d;
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;

  logic [IDX_W-1:0] req_idx, fill_idx;
  logic [TAG_W-1:0] req_tag, fill_tag;
  logic             hit_c, ihit_c, fill_c, iren_c;
  logic [31:0]      imemload_c, iaddr_c;
  logic             unused_byte_offset;

  assign req_idx  = bus.imemaddr[IDX_W+1:2];
  assign req_tag  = bus.imemaddr[31:IDX_W+2];
  assign fill_idx = miss_addr_q[IDX_W+1:2];
  assign fill_tag = miss_addr_q[31:IDX_W+2];
  assign unused_byte_offset = ^bus.imemaddr[1:0];

  assign req_frame = frames_q[req_idx];
  assign hit_c     = (state_q == COMPARE) && bus.imemREN && req_frame.valid &&
                     (req_frame.tag == WADDR_W'(req_tag));

  // Next-state, refill strobe and combinational datapath/memory outputs.
  always_comb begin
    state_d     = state_q;
    miss_addr_d = miss_addr_q;
    hit_cnt_d   = hit_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    fill_c      = 1'b0;
    ihit_c      = 1'b0;
    imemload_c  = '0;
    iren_c      = 1'b0;
    iaddr_c     = '0;
    unique case (state_q)
      COMPARE: begin
        ihit_c = hit_c && !bus.flush;
        if (ihit_c) begin
          imemload_c = req_frame.data;
          hit_cnt_d  = sat_inc(hit_cnt_q);
        end else if (bus.imemREN && !bus.flush) begin
          state_d     = FETCH;
          miss_addr_d = {bus.imemaddr[31:2], 2'b00};
          miss_cnt_d  = sat_inc(miss_cnt_q);
        end
      end
      FETCH: begin
        iren_c  = 1'b1;
        iaddr_c = miss_addr_q;
        // A flush drops the refill even if memory completes this cycle.
        if (bus.flush) begin
          state_d = COMPARE;
        end else if (!bus.iwait) begin
          fill_c  = 1'b1;
          state_d = COMPARE;
        end
      end
      default: state_d = COMPARE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin : ctrl_regs
    if (!nRST) begin
      state_q     <= COMPARE;
      miss_addr_q <= '0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      miss_addr_q <= miss_addr_d;
      hit_cnt_q   <= hit_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin : frame_store
    if (!nRST) begin
      for (int unsigned i = 0; i < FRAMES; i++) begin
        frames_q[IDX_W'(i)] <= '0;
      end
    end else if (bus.flush) begin
      for (int unsigned i = 0; i < FRAMES; i++) begin
        frames_q[IDX_W'(i)].valid <= 1'b0;
      end
    end else if (fill_c) begin
      frames_q[fill_idx] <= '{valid: 1'b1, tag: WADDR_W'(fill_tag), data: bus.iload};
    end
  end

  assign bus.ihit       = ihit_c;
  assign bus.imemload   = imemload_c;
  assign bus.iREN       = iren_c;
  assign bus.iaddr      = iaddr_c;
  assign bus.hit_count  = hit_cnt_q;
  assign bus.miss_count = miss_cnt_q;

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: a cycle table for the cold miss, directed
// corner sequences, then random traffic against a frame-level model.
module tb_icache;

  localparam int unsigned FRAMES = 16;

  logic clk  = 1'b0;
  logic nrst = 1'b0;

  icache_if bus ();

  icache #(.FRAMES(FRAMES)) dut (
    .CLK  (clk),
    .nRST (nrst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    if (a == 32'h0000_0040) return 32'h2001_0005;
    return (a * 32'h9E37_79B1) ^ 32'h0F0F_1357;
  endfunction

  // Memory: holds iwait high for cur_lat FETCH cycles, then one data cycle.
  int lat_cfg  = 3;
  bit lat_rand = 1'b0;
  int wait_cnt = 0;
  int cur_lat  = 0;

  always @(negedge clk or negedge nrst) begin
    if (!nrst) begin
      wait_cnt  = 0;
      bus.iwait = 1'b1;
    end else if (bus.iREN) begin
      if (wait_cnt == 0) cur_lat = lat_rand ? int'($urandom_range(0, 3)) : lat_cfg;
      if (wait_cnt >= cur_lat) begin
        bus.iwait = 1'b0;
        bus.iload = mem_data(bus.iaddr);
        wait_cnt  = 0;
      end else begin
        bus.iwait = 1'b1;
        wait_cnt++;
      end
    end else begin
      bus.iwait = 1'b1;
      wait_cnt  = 0;
    end
  end

  // Reference model: which word address each frame holds, plus outstanding miss.
  bit          mv   [FRAMES];
  logic [29:0] mwa  [FRAMES];
  logic [31:0] mdat [FRAMES];
  bit          busy;
  logic [31:0] pend;
  logic [31:0] m_hits, m_miss;

  function automatic int unsigned fidx(input logic [31:0] a);
    return int'((a >> 2) % FRAMES);
  endfunction

  function automatic bit m_hit();
    int unsigned i;
    if (busy) return 1'b0;
    i = fidx(bus.imemaddr);
    return bus.imemREN && !bus.flush && mv[i] && (mwa[i] == bus.imemaddr[31:2]);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < FRAMES; i++) begin
      mv[i] = 1'b0; mwa[i] = '0; mdat[i] = '0;
    end
    busy = 1'b0; pend = '0; m_hits = '0; m_miss = '0;
  endtask

  task automatic model_edge();
    bit h;
    h = m_hit();
    if (busy) begin
      if (!bus.flush && !bus.iwait) begin
        mv[fidx(pend)]   = 1'b1;
        mwa[fidx(pend)]  = pend[31:2];
        mdat[fidx(pend)] = bus.iload;
      end
      if (bus.flush || !bus.iwait) busy = 1'b0;
    end else if (h) begin
      if (m_hits != 32'hFFFF_FFFF) m_hits++;
    end else if (bus.imemREN && !bus.flush) begin
      busy = 1'b1;
      pend = {bus.imemaddr[31:2], 2'b00};
      if (m_miss != 32'hFFFF_FFFF) m_miss++;
    end
    if (bus.flush) for (int i = 0; i < FRAMES; i++) mv[i] = 1'b0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
    end
  endtask

  task automatic set_in(input logic ren, input logic [31:0] addr, input logic fl);
    bus.imemREN  = ren;
    bus.imemaddr = addr;
    bus.flush    = fl;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic check_model();
    bit h;
    h = m_hit();
    chk("ihit",       32'(bus.ihit), 32'(h));
    chk("imemload",   bus.imemload, h ? mdat[fidx(bus.imemaddr)] : 32'h0);
    chk("iREN",       32'(bus.iREN), 32'(busy));
    chk("iaddr",      bus.iaddr, busy ? pend : 32'h0);
    chk("hit_count",  bus.hit_count, m_hits);
    chk("miss_count", bus.miss_count, m_miss);
  endtask

  task automatic drive(input logic ren, input logic [31:0] addr, input logic fl);
    set_in(ren, addr, fl);
    check_model();
    step();
  endtask

  typedef struct {
    logic        ren;
    logic [31:0] addr;
    logic        hit;
    logic [31:0] load;
    logic        iren;
    logic [31:0] iaddr;
  } vec_t;

  vec_t tbl [7];

  initial begin
    #1_000_000;
    $display("FAIL watchdog t=%0t actual=running required=finished", $time);
    $fatal(1);
  end

  initial begin
    tbl[0] = '{1'b1, 32'h40, 1'b0, 32'h0,         1'b0, 32'h0};
    tbl[1] = '{1'b1, 32'h40, 1'b0, 32'h0,         1'b1, 32'h40};
    tbl[2] = '{1'b1, 32'h40, 1'b0, 32'h0,         1'b1, 32'h40};
    tbl[3] = '{1'b1, 32'h40, 1'b0, 32'h0,         1'b1, 32'h40};
    tbl[4] = '{1'b1, 32'h40, 1'b0, 32'h0,         1'b1, 32'h40};
    tbl[5] = '{1'b1, 32'h40, 1'b1, 32'h2001_0005, 1'b0, 32'h0};
    tbl[6] = '{1'b0, 32'h40, 1'b0, 32'h0,         1'b0, 32'h0};

    bus.imemREN = 1'b0; bus.imemaddr = '0; bus.flush = 1'b0;
    model_reset();

    // Outputs held quiet during reset even with a request present.
    @(posedge clk); @(posedge clk); #1;
    set_in(1'b1, 32'h40, 1'b0);
    chk("rst_ihit",     32'(bus.ihit), 32'h0);
    chk("rst_imemload", bus.imemload, 32'h0);
    chk("rst_iREN",     32'(bus.iREN), 32'h0);
    chk("rst_iaddr",    bus.iaddr, 32'h0);
    chk("rst_hits",     bus.hit_count, 32'h0);
    chk("rst_misses",   bus.miss_count, 32'h0);
    bus.imemREN = 1'b0;
    nrst = 1'b1;
    step();

    // Cold miss on 0x40 with three wait cycles.
    lat_cfg = 3;
    for (int k = 0; k < 7; k++) begin
      set_in(tbl[k].ren, tbl[k].addr, 1'b0);
      chk($sformatf("cold_ihit[%0d]", k),  32'(bus.ihit), 32'(tbl[k].hit));
      chk($sformatf("cold_load[%0d]", k),  bus.imemload, tbl[k].load);
      chk($sformatf("cold_iREN[%0d]", k),  32'(bus.iREN), 32'(tbl[k].iren));
      chk($sformatf("cold_iaddr[%0d]", k), bus.iaddr, tbl[k].iaddr);
      step();
    end
    chk("cold_hit_count",  bus.hit_count, 32'd1);
    chk("cold_miss_count", bus.miss_count, 32'd1);

    // Conflict: 0x80 evicts 0x40 (same index, other tag), then 0x40 misses again.
    for (int k = 0; k < 6; k++) drive(1'b1, 32'h80, 1'b0);
    chk("conflict_miss2", bus.miss_count, 32'd2);
    set_in(1'b1, 32'h40, 1'b0);
    chk("conflict_40_evicted", 32'(bus.ihit), 32'h0);
    check_model(); step();
    for (int k = 0; k < 5; k++) drive(1'b1, 32'h40, 1'b0);
    chk("conflict_miss3", bus.miss_count, 32'd3);

    // Redirect mid-miss: 0x10 fill completes, then 0x20 misses.
    drive(1'b1, 32'h10, 1'b0);
    for (int k = 0; k < 5; k++) drive(1'b1, 32'h20, 1'b0);
    chk("redirect_iREN",  32'(bus.iREN), 32'h1);
    chk("redirect_iaddr", bus.iaddr, 32'h20);
    for (int k = 0; k < 4; k++) drive(1'b1, 32'h20, 1'b0);
    set_in(1'b1, 32'h10, 1'b0);
    chk("redirect_10_hit",  32'(bus.ihit), 32'h1);
    chk("redirect_10_data", bus.imemload, mem_data(32'h10));
    check_model(); step();

    // Flush invalidates a filled frame.
    for (int k = 0; k < 6; k++) drive(1'b1, 32'h04, 1'b0);
    set_in(1'b1, 32'h04, 1'b1);
    chk("flush_forces_no_hit", 32'(bus.ihit), 32'h0);
    check_model(); step();
    set_in(1'b1, 32'h04, 1'b0);
    chk("flush_then_miss", 32'(bus.ihit), 32'h0);
    check_model(); step();
    for (int k = 0; k < 5; k++) drive(1'b1, 32'h04, 1'b0);

    // Flush coincident with refill completion (latency 1: second FETCH cycle).
    lat_cfg = 1;
    drive(1'b1, 32'h08, 1'b0);
    drive(1'b1, 32'h08, 1'b0);
    drive(1'b1, 32'h08, 1'b1);
    set_in(1'b1, 32'h08, 1'b0);
    chk("flush_fill_dropped", 32'(bus.ihit), 32'h0);
    check_model(); step();
    chk("flush_refetch_iaddr", bus.iaddr, 32'h08);
    for (int k = 0; k < 3; k++) drive(1'b1, 32'h08, 1'b0);

    // Asynchronous reset in the middle of a refill.
    lat_cfg = 3;
    drive(1'b1, 32'h100, 1'b0);
    set_in(1'b1, 32'h100, 1'b0);
    nrst = 1'b0;
    #1;
    chk("amid_iREN",     32'(bus.iREN), 32'h0);
    chk("amid_iaddr",    bus.iaddr, 32'h0);
    chk("amid_hits",     bus.hit_count, 32'h0);
    chk("amid_misses",   bus.miss_count, 32'h0);
    model_reset();
    bus.imemREN = 1'b0;
    @(negedge clk); #1;
    nrst = 1'b1;
    step();
    set_in(1'b1, 32'h40, 1'b0);
    chk("post_rst_40_miss", 32'(bus.ihit), 32'h0);
    check_model(); step();
    for (int k = 0; k < 5; k++) drive(1'b1, 32'h40, 1'b0);
    set_in(1'b1, 32'h04, 1'b0);
    chk("post_rst_04_miss", 32'(bus.ihit), 32'h0);
    check_model(); step();
    for (int k = 0; k < 5; k++) drive(1'b1, 32'h04, 1'b0);

    // Random traffic with random memory latency.
    lat_rand = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      logic [31:0] a;
      a = (32'($urandom_range(0, 47)) << 2) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) a = a | 32'h8000_0000;
      drive(($urandom_range(0, 3) != 0), a, ($urandom_range(0, 39) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
